// File: rtl/pong_match_controller.sv
// Match sequencer for a two-player pong game: serve countdown, rally, point display, game over.
// Optional macro WIN_BY_TWO_EN: win needs a two-point lead, with deuce scores folded back by one.
module pong_match_controller #(
  parameter int WIN_SCORE   = 10,
  parameter int SERVE_TICKS = 60,
  parameter int POINT_TICKS = 30
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic       tick,
  input  logic       start,
  input  logic       pause,
  input  logic       p1_point,
  input  logic       p2_point,
  output logic [2:0] state,
  output logic       play_en,
  output logic       ball_reset,
  output logic       serve_dir,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic [1:0] winner
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } state_t;

  localparam logic [3:0] WIN4     = 4'(WIN_SCORE);
  localparam logic [7:0] SERVE_LD = 8'(SERVE_TICKS);
  localparam logic [7:0] POINT_LD = 8'(POINT_TICKS);

  state_t     st_q;
  logic [7:0] countdown;
  logic [3:0] p1_next, p2_next;
  logic       p1_wins, p2_wins;
  logic       tick_en, last_tick;

  assign state     = st_q;
  assign tick_en   = tick && !pause;
  assign last_tick = tick_en && (countdown == 8'd1);

  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s == 4'hF) ? s : s + 4'd1;
  endfunction

  // Scores after a point in PLAY, and the win test applied when POINT expires.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
    p1_next = p1_score;
    p2_next = p2_score;
    if (p1_point && !p2_point) p1_next = sat_inc(p1_score);
    else if (p2_point && !p1_point) p2_next = sat_inc(p2_score);
`ifdef WIN_BY_TWO_EN
    if (p1_next >= WIN4 && p2_next >= WIN4) begin
      p1_next = p1_next - 4'd1;
      p2_next = p2_next - 4'd1;
    end
    p1_wins = (p1_score >= WIN4) && ({1'b0, p1_score} >= {1'b0, p2_score} + 5'd2);
    p2_wins = (p2_score >= WIN4) && ({1'b0, p2_score} >= {1'b0, p1_score} + 5'd2);
`else
    p1_wins = (p1_score == WIN4);
    p2_wins = (p2_score == WIN4);
`endif
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      st_q       <= IDLE;
      countdown  <= 8'd0;
      p1_score   <= 4'd0;
      p2_score   <= 4'd0;
      winner     <= 2'b00;
      serve_dir  <= 1'b1;
      ball_reset <= 1'b0;
      play_en    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values, as real flops do.
      ball_reset <= 1'b0;
      play_en    <= 1'b0;
      case (st_q)
        IDLE, OVER: begin
          if (start) begin
            st_q       <= SERVE;
            p1_score   <= 4'd0;
            p2_score   <= 4'd0;
            winner     <= 2'b00;
            ball_reset <= 1'b1;
            countdown  <= SERVE_LD;
          end
        end
        SERVE: begin
          if (last_tick) begin
            st_q      <= PLAY;
            countdown <= 8'd0;
            play_en   <= 1'b1;
          end else if (tick_en) begin
            countdown <= countdown - 8'd1;
          end
        end
        PLAY: begin
          // Points are taken even while paused; a double point is a replay.
          if (p1_point || p2_point) begin
            st_q      <= POINT;
            countdown <= POINT_LD;
            p1_score  <= p1_next;
            p2_score  <= p2_next;
            if (p1_point && !p2_point) serve_dir <= 1'b1;
            else if (p2_point && !p1_point) serve_dir <= 1'b0;
          end else begin
            play_en <= !pause;
          end
        end
        POINT: begin
          if (last_tick) begin
            if (p1_wins || p2_wins) begin
              st_q      <= OVER;
              winner    <= {p2_wins, p1_wins};
              countdown <= 8'd0;
            end else begin
              st_q       <= SERVE;
              ball_reset <= 1'b1;
              countdown  <= SERVE_LD;
            end
          end else if (tick_en) begin
            countdown <= countdown - 8'd1;
          end
        end
        default: st_q <= IDLE;
      endcase
    end
  end

endmodule
